// File: rtl/sram_phase_sequencer.sv
// Phase controller for the image decompressor: UART load -> M1 -> optional M2 -> VGA display,
// owning the single SRAM controller port and aborting a stalled milestone via a stage watchdog.
module sram_phase_sequencer #(
    parameter logic [25:0] UART_TIMEOUT  = 26'd49999999,
    parameter logic [27:0] STAGE_TIMEOUT = 28'd200000000,
    parameter logic        M2_EN         = 1'b1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        UART_RX_I,
    input  logic [17:0] UART_address,
    input  logic [15:0] UART_write_data,
    input  logic        UART_we_n,
    output logic        UART_init,
    output logic        UART_enable,
    input  logic [17:0] M1_address,
    input  logic [15:0] M1_write_data,
    input  logic        M1_we_n,
    output logic        M1_start,
    input  logic        M1_done,
    input  logic [17:0] M2_address,
    input  logic [15:0] M2_write_data,
    input  logic        M2_we_n,
    output logic        M2_start,
    input  logic        M2_done,
    input  logic [17:0] VGA_address,
    output logic        VGA_enable,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic [1:0]  phase,
    output logic        stage_error
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_UART_RX = 2'd1,
        S_M1      = 2'd2,
        S_M2      = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [25:0] uart_timer_r, uart_timer_s;
    logic [27:0] stage_timer_r, stage_timer_s;
    logic        vga_enable_r, vga_enable_s;
    logic        uart_init_r, uart_init_s;
    logic        uart_enable_r, uart_enable_s;
    logic        m1_start_r, m1_start_s;
    logic        m2_start_r, m2_start_s;
    logic        stage_error_r, stage_error_s;

    function automatic logic [25:0] sat_inc_26(input logic [25:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + 26'd1;
        end
    endfunction

    function automatic logic [27:0] sat_inc_28(input logic [27:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + 28'd1;
        end
    endfunction

    // Next-state and next-output logic for the phase FSM
    always_comb begin
        state_s       = state_r;
        uart_timer_s  = uart_timer_r;
        stage_timer_s = stage_timer_r;
        vga_enable_s  = vga_enable_r;
        uart_init_s   = 1'b0;
        uart_enable_s = 1'b0;
        m1_start_s    = m1_start_r;
        m2_start_s    = m2_start_r;
        stage_error_s = stage_error_r;
        case (state_r)
            S_IDLE: begin
                if (UART_RX_I == 1'b0) begin
                    uart_init_s  = 1'b1;
                    vga_enable_s = 1'b0;
                    uart_timer_s = 26'd0;
                    state_s      = S_UART_RX;
                end else begin
                    vga_enable_s = 1'b1;
                end
            end
            S_UART_RX: begin
                uart_enable_s = uart_init_r;
                // A write in the expiry cycle keeps the load alive
                if (UART_we_n == 1'b0) begin
                    uart_timer_s = 26'd0;
                end else if (uart_timer_r == UART_TIMEOUT) begin
                    uart_timer_s  = 26'd0;
                    stage_timer_s = 28'd0;
                    m1_start_s    = 1'b1;
                    state_s       = S_M1;
                end else begin
                    uart_timer_s = sat_inc_26(uart_timer_r);
                end
            end
            S_M1: begin
                if (M1_done == 1'b1) begin
                    m1_start_s    = 1'b0;
                    stage_timer_s = 28'd0;
                    if (M2_EN == 1'b1) begin
                        m2_start_s = 1'b1;
                        state_s    = S_M2;
                    end else begin
                        vga_enable_s = 1'b1;
                        state_s      = S_IDLE;
                    end
                end else if (stage_timer_r == STAGE_TIMEOUT) begin
                    m1_start_s    = 1'b0;
                    stage_error_s = 1'b1;
                    vga_enable_s  = 1'b1;
                    stage_timer_s = 28'd0;
                    state_s       = S_IDLE;
                end else begin
                    stage_timer_s = sat_inc_28(stage_timer_r);
                end
            end
            S_M2: begin
                if (M2_done == 1'b1) begin
                    m2_start_s    = 1'b0;
                    stage_timer_s = 28'd0;
                    vga_enable_s  = 1'b1;
                    state_s       = S_IDLE;
                end else if (stage_timer_r == STAGE_TIMEOUT) begin
                    m2_start_s    = 1'b0;
                    stage_error_s = 1'b1;
                    vga_enable_s  = 1'b1;
                    stage_timer_s = 28'd0;
                    state_s       = S_IDLE;
                end else begin
                    stage_timer_s = sat_inc_28(stage_timer_r);
                end
            end
            default: begin
                state_s      = S_IDLE;
                vga_enable_s = 1'b1;
                m1_start_s   = 1'b0;
                m2_start_s   = 1'b0;
            end
        endcase
    end

    // State, timers and registered control outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r       <= S_IDLE;
            uart_timer_r  <= 26'd0;
            stage_timer_r <= 28'd0;
            vga_enable_r  <= 1'b1;
            uart_init_r   <= 1'b0;
            uart_enable_r <= 1'b0;
            m1_start_r    <= 1'b0;
            m2_start_r    <= 1'b0;
            stage_error_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            uart_timer_r  <= uart_timer_s;
            stage_timer_r <= stage_timer_s;
            vga_enable_r  <= vga_enable_s;
            uart_init_r   <= uart_init_s;
            uart_enable_r <= uart_enable_s;
            m1_start_r    <= m1_start_s;
            m2_start_r    <= m2_start_s;
            stage_error_r <= stage_error_s;
        end
    end

    // SRAM port owner follows the state register directly
    always_comb begin
        SRAM_address    = VGA_address;
        SRAM_write_data = 16'd0;
        SRAM_we_n       = 1'b1;
        case (state_r)
            S_IDLE: begin
                SRAM_address    = VGA_address;
                SRAM_write_data = 16'd0;
                SRAM_we_n       = 1'b1;
            end
            S_UART_RX: begin
                SRAM_address    = UART_address;
                SRAM_write_data = UART_write_data;
                SRAM_we_n       = UART_we_n;
            end
            S_M1: begin
                SRAM_address    = M1_address;
                SRAM_write_data = M1_write_data;
                SRAM_we_n       = M1_we_n;
            end
            S_M2: begin
                SRAM_address    = M2_address;
                SRAM_write_data = M2_write_data;
                SRAM_we_n       = M2_we_n;
            end
            default: begin
                SRAM_address    = VGA_address;
                SRAM_write_data = 16'd0;
                SRAM_we_n       = 1'b1;
            end
        endcase
    end

    assign phase       = state_r;
    assign VGA_enable  = vga_enable_r;
    assign UART_init   = uart_init_r;
    assign UART_enable = uart_enable_r;
    assign M1_start    = m1_start_r;
    assign M2_start    = m2_start_r;
    assign stage_error = stage_error_r;

endmodule

// File: tb/tb_sram_phase_sequencer.sv
// Scoreboard bench for sram_phase_sequencer: three instances with different parameters share
// stimulus; each is held in reset while another is under test.
module tb_sram_phase_sequencer;

    localparam int F_PHASE = 0, F_VGA = 1, F_INIT = 2, F_UEN = 3, F_M1S = 4, F_M2S = 5,
                   F_ERR = 6, F_SADDR = 7, F_SWD = 8, F_SWE = 9, F_M2SEEN = 10;

    typedef struct {
        int          cyc;
        int          dut;
        int          field;
        logic [17:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic [2:0]  rst;
    logic        UART_RX_I, UART_we_n, M1_we_n, M2_we_n, M1_done, M2_done;
    logic [17:0] UART_address, M1_address, M2_address, VGA_address;
    logic [15:0] UART_write_data, M1_write_data, M2_write_data;

    logic        init_w[3], uen_w[3], m1s_w[3], m2s_w[3], vga_w[3], err_w[3], swe_w[3];
    logic [17:0] saddr_w[3];
    logic [15:0] swd_w[3];
    logic [1:0]  phase_w[3];

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic m2_seen = 1'b0;
    logic [17:0] mon_act;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sram_phase_sequencer #(
            .UART_TIMEOUT  ((g == 0) ? 26'd1000 : 26'd50),
            .STAGE_TIMEOUT ((g == 2) ? 28'd20 : 28'd100),
            .M2_EN         ((g == 1) ? 1'b0 : 1'b1)
        ) u_dut (
            .Clock(clk), .Reset(rst[g]), .UART_RX_I(UART_RX_I),
            .UART_address(UART_address), .UART_write_data(UART_write_data),
            .UART_we_n(UART_we_n), .UART_init(init_w[g]), .UART_enable(uen_w[g]),
            .M1_address(M1_address), .M1_write_data(M1_write_data), .M1_we_n(M1_we_n),
            .M1_start(m1s_w[g]), .M1_done(M1_done),
            .M2_address(M2_address), .M2_write_data(M2_write_data), .M2_we_n(M2_we_n),
            .M2_start(m2s_w[g]), .M2_done(M2_done),
            .VGA_address(VGA_address), .VGA_enable(vga_w[g]),
            .SRAM_address(saddr_w[g]), .SRAM_write_data(swd_w[g]), .SRAM_we_n(swe_w[g]),
            .phase(phase_w[g]), .stage_error(err_w[g])
        );
    end

    function automatic logic [17:0] get_field(input int d, input int f);
        case (f)
            F_PHASE:  return {16'd0, phase_w[d]};
            F_VGA:    return {17'd0, vga_w[d]};
            F_INIT:   return {17'd0, init_w[d]};
            F_UEN:    return {17'd0, uen_w[d]};
            F_M1S:    return {17'd0, m1s_w[d]};
            F_M2S:    return {17'd0, m2s_w[d]};
            F_ERR:    return {17'd0, err_w[d]};
            F_SADDR:  return saddr_w[d];
            F_SWD:    return {2'd0, swd_w[d]};
            F_SWE:    return {17'd0, swe_w[d]};
            F_M2SEEN: return {17'd0, m2_seen};
            default:  return 18'h3FFFF;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int d, input int f, input logic [17:0] v, input string nm);
        exp_t e;
        e.cyc = cyc; e.dut = d; e.field = f; e.val = v; e.name = nm;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (m2s_w[1] === 1'b1) m2_seen = 1'b1;
    end

    // Monitor: pops every expectation stamped for this cycle and compares it to the DUT
    always @(negedge clk) begin
        while (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            mon_act = get_field(mon_e.dut, mon_e.field);
            n_checks++;
            if (mon_e.cyc == cyc && mon_act === mon_e.val) begin
                n_pass++;
            end else begin
                $display("FAIL %s (dut%0d, cycle %0d): got %h, expected %h",
                         mon_e.name, mon_e.dut, cyc, mon_act, mon_e.val);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL sim_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 3'b111;
        UART_RX_I = 1'b1; UART_we_n = 1'b1; M1_we_n = 1'b1; M2_we_n = 1'b1;
        M1_done = 1'b0; M2_done = 1'b0;
        UART_address = 18'd0; M1_address = 18'd0; M2_address = 18'd0;
        VGA_address = 18'h2AAAA;
        UART_write_data = 16'd0; M1_write_data = 16'd0; M2_write_data = 16'd0;
        repeat (3) tick();

        // Reset state
        chk(0, F_PHASE, 18'd0, "rst_phase");
        chk(0, F_VGA, 18'd1, "rst_vga");
        chk(0, F_SADDR, 18'h2AAAA, "rst_sram_addr");
        chk(0, F_SWE, 18'd1, "rst_sram_we");
        chk(0, F_ERR, 18'd0, "rst_err");
        chk(0, F_M1S, 18'd0, "rst_m1s");
        chk(0, F_INIT, 18'd0, "rst_init");
        rst[0] = 1'b0;
        tick();
        chk(0, F_PHASE, 18'd0, "idle_hold");

        // UART load with periodic writes and a write exactly at expiry
        UART_address = 18'h00100; UART_write_data = 16'h5A5A;
        UART_RX_I = 1'b0; tick(); UART_RX_I = 1'b1;
        chk(0, F_PHASE, 18'd1, "uart_phase");
        chk(0, F_INIT, 18'd1, "uart_init_hi");
        chk(0, F_UEN, 18'd0, "uart_en_lo");
        chk(0, F_VGA, 18'd0, "uart_vga_off");
        chk(0, F_SADDR, 18'h00100, "uart_sram_addr");
        chk(0, F_SWD, 18'h05A5A, "uart_sram_wd");
        tick();
        chk(0, F_INIT, 18'd0, "uart_init_drop");
        chk(0, F_UEN, 18'd1, "uart_en_hi");
        tick();
        chk(0, F_UEN, 18'd0, "uart_en_drop");
        for (int k = 0; k < 10; k++) begin
            repeat (99) tick();
            UART_we_n = 1'b0; tick(); UART_we_n = 1'b1;
        end
        UART_RX_I = 1'b0; tick(); UART_RX_I = 1'b1;
        chk(0, F_INIT, 18'd0, "rx_ignored_init");
        chk(0, F_PHASE, 18'd1, "rx_ignored_phase");
        repeat (999) tick();
        chk(0, F_PHASE, 18'd1, "uart_at_limit");
        UART_we_n = 1'b0; tick(); UART_we_n = 1'b1;
        chk(0, F_PHASE, 18'd1, "we_clear_wins");
        repeat (1000) tick();
        chk(0, F_PHASE, 18'd1, "uart_pre_timeout");
        tick();
        chk(0, F_PHASE, 18'd2, "m1_entry_1001");
        chk(0, F_M1S, 18'd1, "m1_start_hi");
        chk(0, F_VGA, 18'd0, "m1_vga_off");

        // M1 owns SRAM; M1 -> M2 handoff
        M1_address = 18'h01234; M1_write_data = 16'hBEEF; M1_we_n = 1'b0;
        chk(0, F_SADDR, 18'h01234, "m1_sram_addr");
        chk(0, F_SWD, 18'h0BEEF, "m1_sram_wd");
        chk(0, F_SWE, 18'd0, "m1_sram_we");
        M2_done = 1'b1; tick(); M2_done = 1'b0;
        chk(0, F_PHASE, 18'd2, "m2_done_ignored");
        chk(0, F_M2S, 18'd0, "m2_start_lo_in_m1");
        repeat (48) tick();
        M1_done = 1'b1; tick(); M1_done = 1'b0;
        chk(0, F_PHASE, 18'd3, "m2_entry");
        chk(0, F_M1S, 18'd0, "m1_start_drop");
        chk(0, F_M2S, 18'd1, "m2_start_rise");
        chk(0, F_ERR, 18'd0, "m2_no_err");
        M1_we_n = 1'b1;
        M2_address = 18'h3ABCD; M2_write_data = 16'h1357; M2_we_n = 1'b0;
        chk(0, F_SADDR, 18'h3ABCD, "m2_sram_addr");
        chk(0, F_SWD, 18'h01357, "m2_sram_wd");
        chk(0, F_SWE, 18'd0, "m2_sram_we");

        // M2_done on the watchdog cycle: done wins
        repeat (100) tick();
        chk(0, F_PHASE, 18'd3, "m2_at_limit");
        M2_done = 1'b1; tick(); M2_done = 1'b0; M2_we_n = 1'b1;
        chk(0, F_PHASE, 18'd0, "done_vs_wd_phase");
        chk(0, F_ERR, 18'd0, "done_vs_wd_err");
        chk(0, F_VGA, 18'd1, "done_vs_wd_vga");
        chk(0, F_M2S, 18'd0, "done_vs_wd_m2s");
        chk(0, F_SADDR, 18'h2AAAA, "idle_sram_addr");
        chk(0, F_SWE, 18'd1, "idle_sram_we");

        // Reset in S_M2
        UART_RX_I = 1'b0; tick(); UART_RX_I = 1'b1;
        repeat (1001) tick();
        chk(0, F_PHASE, 18'd2, "reload_m1");
        M1_done = 1'b1; tick(); M1_done = 1'b0;
        chk(0, F_PHASE, 18'd3, "reload_m2");
        rst[0] = 1'b1; tick();
        chk(0, F_PHASE, 18'd0, "m2_rst_phase");
        chk(0, F_M1S, 18'd0, "m2_rst_m1s");
        chk(0, F_M2S, 18'd0, "m2_rst_m2s");
        chk(0, F_VGA, 18'd1, "m2_rst_vga");

        // M2_EN = 0: M1 returns to display
        rst[1] = 1'b0; tick();
        UART_RX_I = 1'b0; tick(); UART_RX_I = 1'b1;
        chk(1, F_PHASE, 18'd1, "noM2_uart");
        repeat (51) tick();
        chk(1, F_PHASE, 18'd2, "noM2_m1");
        chk(1, F_M1S, 18'd1, "noM2_m1s");
        M1_done = 1'b1; tick(); M1_done = 1'b0;
        chk(1, F_PHASE, 18'd0, "noM2_idle");
        chk(1, F_VGA, 18'd1, "noM2_vga");
        chk(1, F_M1S, 18'd0, "noM2_m1s_drop");
        chk(1, F_ERR, 18'd0, "noM2_err");
        tick();
        chk(1, F_M2SEEN, 18'd0, "noM2_m2_never");
        rst[1] = 1'b1;

        // Watchdog abort, then sticky error across a new load
        rst[2] = 1'b0; tick();
        UART_RX_I = 1'b0; tick(); UART_RX_I = 1'b1;
        repeat (51) tick();
        chk(2, F_PHASE, 18'd2, "wd_m1");
        repeat (20) tick();
        chk(2, F_PHASE, 18'd2, "wd_at_limit");
        chk(2, F_ERR, 18'd0, "wd_no_err_yet");
        tick();
        chk(2, F_PHASE, 18'd0, "wd_abort_phase");
        chk(2, F_ERR, 18'd1, "wd_err_set");
        chk(2, F_M1S, 18'd0, "wd_m1s_drop");
        chk(2, F_VGA, 18'd1, "wd_vga");
        UART_RX_I = 1'b0; tick(); UART_RX_I = 1'b1;
        chk(2, F_PHASE, 18'd1, "reload_uart");
        chk(2, F_ERR, 18'd1, "err_sticky_uart");
        repeat (51) tick();
        chk(2, F_PHASE, 18'd2, "reload2_m1");
        chk(2, F_ERR, 18'd1, "err_sticky_m1");

        repeat (2) tick();
        if (sb_q.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
            n_checks += sb_q.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
